// File: rtl/muldiv_pkg.sv
// Shared types, defaults and the sign helper for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_XLEN_DEF = 32;

    typedef enum logic [2:0] {IDLE, INIT, RUN, FIX, DONE} md_state_t;
    typedef enum logic {OP_MULT, OP_DIV} md_op_t;

    // Conditional two's-complement negate: magnitude on the way in, sign restore on the way out.
    function automatic logic [MD_XLEN_DEF-1:0] abs_val(input logic [MD_XLEN_DEF-1:0] v,
                                                       input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide sequencer bundle; master is the EX side, slave is the sequencer.
interface muldiv_if import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN_DEF
);

    logic            start_mult;
    logic            start_div;
    logic            signed_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            ex_hilo_use;
    logic            busy;
    logic            stall_req;
    logic            hi_wr_en;
    logic            lo_wr_en;
    logic [XLEN-1:0] hi_res;
    logic [XLEN-1:0] lo_res;
    logic            div_by_zero;

    modport master (
        output start_mult, start_div, signed_op, op_a, op_b, flush, ex_hilo_use,
        input  busy, stall_req, hi_wr_en, lo_wr_en, hi_res, lo_res, div_by_zero
    );

    modport slave (
        input  start_mult, start_div, signed_op, op_a, op_b, flush, ex_hilo_use,
        output busy, stall_req, hi_wr_en, lo_wr_en, hi_res, lo_res, div_by_zero
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step, purely combinational.
module muldiv_iter_core import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN_DEF
) (
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] opr_i,
    input  logic [XLEN-1:0] src_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] opr_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    // Multiply keeps {acc, opr} as the product shifting right; divide shifts the dividend
    // out of opr into acc and shifts quotient bits into opr from the bottom.
    always_comb begin
        sum   = {1'b0, acc_i} + (opr_i[0] ? {1'b0, src_i} : '0);
        part  = {acc_i, opr_i[XLEN-1]};
        diff  = part - {1'b0, src_i};
        acc_o = acc_i;
        opr_o = opr_i;
        if (op_i == OP_MULT) begin
            acc_o = sum[XLEN:1];
            opr_o = {sum[0], opr_i[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_o = diff[XLEN-1:0];
            opr_o = {opr_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = part[XLEN-1:0];
            opr_o = {opr_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, operand/accumulator registers, sign fix-up and stall request.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module muldiv_seq_ctrl import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN_DEF
) (
    input logic      clk,
    input logic      reset_n,
    muldiv_if.slave  bus
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN - 1);

    md_state_t       state_q, state_d;
    md_op_t          op_q, op_d;
    logic            sgn_q, sgn_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] src_q, src_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opr_q, opr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_p_q, sign_p_d;
    logic            sign_r_q, sign_r_d;
    logic            dbz_q, dbz_d;
    logic [XLEN-1:0] hi_res_q, hi_res_d;
    logic [XLEN-1:0] lo_res_q, lo_res_d;

    logic [XLEN-1:0]   step_acc;
    logic [XLEN-1:0]   step_opr;
    logic              sign_a;
    logic              sign_b;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;

    assign sign_a   = sgn_q & a_q[XLEN-1];
    assign sign_b   = sgn_q & b_q[XLEN-1];
    assign prod     = {acc_q, opr_q};
    assign prod_fix = sign_p_q ? -prod : prod;

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] low_mask;
    assign low_mask = (XLEN'(1) << cnt_q) - XLEN'(1);
`endif

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .op_i  (op_q),
        .acc_i (acc_q),
        .opr_i (opr_q),
        .src_i (src_q),
        .acc_o (step_acc),
        .opr_o (step_opr)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        a_d      = a_q;
        b_d      = b_q;
        src_d    = src_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        cnt_d    = cnt_q;
        sign_p_d = sign_p_q;
        sign_r_d = sign_r_q;
        dbz_d    = dbz_q;
        hi_res_d = hi_res_q;
        lo_res_d = lo_res_q;

        case (state_q)
            IDLE: begin
                if ((bus.start_mult | bus.start_div) & !bus.flush) begin
                    state_d = INIT;
                    op_d    = bus.start_mult ? OP_MULT : OP_DIV;
                    sgn_d   = bus.signed_op;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                end
            end
            INIT: begin
                sign_p_d = sign_a ^ sign_b;
                sign_r_d = sign_a;
                acc_d    = '0;
                cnt_d    = CNT_MAX;
                dbz_d    = (op_q == OP_DIV) && (b_q == '0);
                if (op_q == OP_MULT) begin
                    src_d = abs_val(a_q, sign_a);
                    opr_d = abs_val(b_q, sign_b);
                end else begin
                    src_d = abs_val(b_q, sign_b);
                    opr_d = abs_val(a_q, sign_a);
                end
                // A zero divisor skips the engine and reports the raw dividend as remainder.
                if ((op_q == OP_DIV) && (b_q == '0)) begin
                    state_d  = DONE;
                    hi_res_d = a_q;
                    lo_res_d = '1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                opr_d = step_opr;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`ifdef MULDIV_EARLY_OUT_EN
                // The skipped iterations would only shift, so apply them all at once.
                if ((op_q == OP_MULT) && (((opr_q >> 1) & low_mask) == '0)) begin
                    {acc_d, opr_d} = {step_acc, step_opr} >> cnt_q;
                    cnt_d          = '0;
                    state_d        = FIX;
                end
`endif
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    hi_res_d = prod_fix[2*XLEN-1:XLEN];
                    lo_res_d = prod_fix[XLEN-1:0];
                end else begin
                    lo_res_d = abs_val(opr_q, sign_p_q);
                    hi_res_d = abs_val(acc_q, sign_r_q);
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            hi_res_d = hi_res_q;
            lo_res_d = lo_res_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            src_q    <= '0;
            acc_q    <= '0;
            opr_q    <= '0;
            cnt_q    <= '0;
            sign_p_q <= 1'b0;
            sign_r_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_res_q <= '0;
            lo_res_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            src_q    <= src_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            cnt_q    <= cnt_d;
            sign_p_q <= sign_p_d;
            sign_r_q <= sign_r_d;
            dbz_q    <= dbz_d;
            hi_res_q <= hi_res_d;
            lo_res_q <= lo_res_d;
        end
    end

    // Strobes are suppressed if a flush lands on the DONE cycle itself.
    assign bus.busy        = (state_q != IDLE);
    assign bus.stall_req   = bus.busy & (bus.start_mult | bus.start_div | bus.ex_hilo_use);
    assign bus.hi_wr_en    = (state_q == DONE) & !bus.flush;
    assign bus.lo_wr_en    = (state_q == DONE) & !bus.flush;
    assign bus.div_by_zero = (state_q == DONE) & !bus.flush & dbz_q;
    assign bus.hi_res      = hi_res_q;
    assign bus.lo_res      = lo_res_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed self-checking bench for muldiv_seq_ctrl; latencies are counted in clock edges after accept.
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_M73 = 5;
    localparam int LAT_M51 = 4;
    localparam int LAT_M67 = 6;
`else
    localparam int LAT_M73 = 35;
    localparam int LAT_M51 = 35;
    localparam int LAT_M67 = 35;
`endif

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_seq_ctrl #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called just after a posedge while the sequencer is idle; returns just after the accept edge.
    task automatic applyStimulus(input logic isMult, input logic isSigned,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.start_mult = isMult;
        bus.start_div  = !isMult;
        bus.signed_op  = isSigned;
        bus.op_a       = a;
        bus.op_b       = b;
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = 32'hDEAD_BEEF;
        bus.op_b       = 32'h1234_5678;
    endtask

    task automatic runOp(input logic isMult, input logic isSigned,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dbz, output logic loWr);
        applyStimulus(isMult, isSigned, a, b);
        lat  = -1;
        hi   = '0;
        lo   = '0;
        dbz  = 1'b0;
        loWr = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.hi_wr_en) begin
                lat  = k;
                hi   = bus.hi_res;
                lo   = bus.lo_res;
                dbz  = bus.div_by_zero;
                loWr = bus.lo_wr_en;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [31:0] hi, lo;
    logic        dbz, loWr;
    int          stallCount, strobeAt, strobes, busyAfter;

    initial begin
        reset_n         = 1'b0;
        bus.start_mult  = 1'b0;
        bus.start_div   = 1'b0;
        bus.signed_op   = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.flush       = 1'b0;
        bus.ex_hilo_use = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_hi_wr", bus.hi_wr_en, 0);
        checkOutput("reset_lo_res", bus.lo_res, 0);
        checkOutput("reset_hi_res", bus.hi_res, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        runOp(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, hi, lo, dbz, loWr);
        checkOutput("multu_max_lat", lat, 35);
        checkOutput("multu_max_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_max_lo", lo, 32'h0000_0001);
        checkOutput("multu_max_lo_wr", loWr, 1);
        checkOutput("multu_max_dbz", dbz, 0);

        runOp(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd3, lat, hi, lo, dbz, loWr);
        checkOutput("mult_neg7x3_lat", lat, LAT_M73);
        checkOutput("mult_neg7x3_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_neg7x3_lo", lo, 32'hFFFF_FFEB);

        runOp(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, hi, lo, dbz, loWr);
        checkOutput("div_neg7by2_lat", lat, 35);
        checkOutput("div_neg7by2_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_neg7by2_hi", hi, 32'hFFFF_FFFF);

        runOp(1'b0, 1'b0, 32'd100, 32'd0, lat, hi, lo, dbz, loWr);
        checkOutput("divu_by0_lat", lat, 2);
        checkOutput("divu_by0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("divu_by0_hi", hi, 32'd100);
        checkOutput("divu_by0_flag", dbz, 1);

        runOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, dbz, loWr);
        checkOutput("div_ovf_lo", lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi, 32'h0);
        checkOutput("div_ovf_dbz", dbz, 0);

        runOp(1'b0, 1'b0, 32'd100, 32'd7, lat, hi, lo, dbz, loWr);
        checkOutput("divu_100by7_lo", lo, 32'd14);
        checkOutput("divu_100by7_hi", hi, 32'd2);
        @(negedge clk);
        checkOutput("hold_no_strobe", bus.hi_wr_en, 0);
        checkOutput("hold_hi_res", bus.hi_res, 32'd2);
        @(posedge clk);
        #1;

        runOp(1'b1, 1'b0, 32'd5, 32'd1, lat, hi, lo, dbz, loWr);
        checkOutput("multu_5x1_lat", lat, LAT_M51);
        checkOutput("multu_5x1_lo", lo, 32'd5);
        checkOutput("multu_5x1_hi", hi, 32'd0);

        // MFLO enters EX at accept+5 and waits for the write.
        applyStimulus(1'b1, 1'b0, 32'd6, 32'd7);
        stallCount = 0;
        strobeAt   = -1;
        for (int k = 1; k <= 60; k++) begin
            bus.ex_hilo_use = (k >= 5);
            @(negedge clk);
            if (k == 1) begin
                checkOutput("add_in_ex_no_stall", bus.stall_req, 0);
                checkOutput("busy_while_running", bus.busy, 1);
            end
            if (bus.stall_req) stallCount++;
            if (bus.hi_wr_en) begin
                strobeAt = k;
                checkOutput("stall_in_done", bus.stall_req, 1);
            end
            if ((strobeAt != -1) && (k == strobeAt + 1)) begin
                checkOutput("stall_released", bus.stall_req, 0);
                checkOutput("mflo_sees_new_lo", bus.lo_res, 32'd42);
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.ex_hilo_use = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mflo_op_lat", strobeAt, LAT_M67);
        checkOutput("mflo_stall_cycles", stallCount, LAT_M67 - 4);

        // Flush at accept+10 together with a fresh MULT that must be dropped.
        applyStimulus(1'b1, 1'b0, 32'd3, 32'h8000_0000);
        strobes   = 0;
        busyAfter = 0;
        for (int k = 1; k <= 60; k++) begin
            bus.flush      = (k == 10);
            bus.start_mult = (k == 10);
            bus.op_a       = 32'd9;
            bus.op_b       = 32'd9;
            @(negedge clk);
            if (k == 10) checkOutput("busy_in_flush_cycle", bus.busy, 1);
            if (k == 11) checkOutput("busy_after_flush", bus.busy, 0);
            if ((k >= 11) && bus.busy) busyAfter++;
            if (bus.hi_wr_en) strobes++;
            @(posedge clk);
            #1;
        end
        bus.flush      = 1'b0;
        bus.start_mult = 1'b0;
        checkOutput("flush_no_strobe", strobes, 0);
        checkOutput("flush_new_mult_dropped", busyAfter, 0);

        bus.flush      = 1'b1;
        bus.start_mult = 1'b1;
        @(posedge clk);
        #1;
        bus.flush      = 1'b0;
        bus.start_mult = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_start_ignored", bus.busy, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of cycle accept+20.
        applyStimulus(1'b1, 1'b0, 32'd2, 32'hFFFF_FFFF);
        repeat (19) @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", bus.busy, 0);
        checkOutput("async_reset_lo_res", bus.lo_res, 0);
        checkOutput("async_reset_hi_wr", bus.hi_wr_en, 0);
        @(negedge clk);
        reset_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.hi_wr_en || bus.busy) strobes++;
        end
        checkOutput("after_reset_quiet", strobes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
